dense_layer_seq: RTL

//  Time-multiplexed fully-connected layer: NUM_NEURONS neurons computed by NUM_LANES

---
 rtl/dense_layer_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully-connected layer; NUM_LANES signed MAC lanes walk the
// neuron groups in turn, weights streamed from a 1-cycle-latency memory. Optional per-neuron bias
// is enabled by defining DENSE_LAYER_SEQ_BIAS_EN.
module dense_layer_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 16,
    parameter int NUM_LANES   = 4,
    parameter int ACTIVATION  = 0,
    localparam int NUM_GROUPS = NUM_NEURONS / NUM_LANES,
    localparam int ADDR_W     = (NUM_GROUPS * NUM_INPUTS > 1) ? $clog2(NUM_GROUPS * NUM_INPUTS) : 1
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    inputs_valid,
    output logic                                    inputs_ready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]   inputs,
    output logic [ADDR_W-1:0]                       weight_addr,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]         weight_data,
`ifdef DENSE_LAYER_SEQ_BIAS_EN
    input  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]  bias,
`endif
    output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]  outputs,
    output logic                                    outputs_valid,
    input  logic                                    outputs_ready,
    output logic                                    busy
);

    localparam int DW    = DATA_WIDTH;
    localparam int ACC_W = 2 * DW + $clog2(NUM_INPUTS) + 1;
    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(NUM_INPUTS);
    localparam logic [CNT_W-1:0] CNT_LAST_ADDR = CNT_W'(NUM_INPUTS - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GROUPS - 1);

    localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW+1:0] HS_HALF = $signed({{(DW+1){1'b0}}, 1'b1}) <<< (FRAC_BITS - 1);
    localparam logic signed [DW+1:0] HS_ONE  = $signed({{(DW+1){1'b0}}, 1'b1}) <<< FRAC_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_WRITE, ST_DONE} state_t;

    state_t                                  state_q, state_d;
    logic [NUM_INPUTS-1:0][DW-1:0]           inputs_q, inputs_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic [GRP_W-1:0]                        grp_q, grp_d;
    logic [ADDR_W-1:0]                       addr_q, addr_d;
    logic signed [ACC_W-1:0]                 acc_q [NUM_LANES];
    logic signed [ACC_W-1:0]                 acc_d [NUM_LANES];
    logic signed [ACC_W-1:0]                 acc_init_s [NUM_LANES];
    logic signed [2*DW-1:0]                  prod_s [NUM_LANES];
    logic [NUM_NEURONS-1:0][DW-1:0]          outputs_q, outputs_d;
    logic                                    valid_q, valid_d;
    logic                                    busy_q, busy_d;
    logic                                    ready_q, ready_d;
    logic [IDX_W-1:0]                        mac_idx_s;

    // Floor-shift the accumulator back to Q format and saturate to the output range.
    function automatic logic [DW-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC_BITS;
        if (sh > ACC_MAX) sat_shift = OUT_MAX;
        else if (sh < ACC_MIN) sat_shift = OUT_MIN;
        else sat_shift = sh[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] activate(input logic [DW-1:0] x);
        logic signed [DW+1:0] hs;
        hs = $signed({{2{x[DW-1]}}, x}) >>> 2;
        hs = hs + HS_HALF;
        case (ACTIVATION)
            0: activate = x[DW-1] ? '0 : x;
            1: activate = x;
            2: begin
                if (hs[DW+1]) activate = '0;
                else if (hs > HS_ONE) activate = HS_ONE[DW-1:0];
                else activate = hs[DW-1:0];
            end
            default: activate = x;
        endcase
    endfunction

    // The data returned this cycle belongs to the address issued one cycle earlier.
    assign mac_idx_s = IDX_W'(cnt_q - CNT_W'(1));

    // Per-lane signed products of the current input and its streamed weight.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            prod_s[l] = $signed(inputs_q[mac_idx_s]) * $signed(weight_data[l*DW +: DW]);
        end
    end

`ifdef DENSE_LAYER_SEQ_BIAS_EN
    logic [GRP_W-1:0] init_grp_s;
    assign init_grp_s = (state_q == ST_WRITE) ? grp_q + GRP_W'(1) : '0;

    // Accumulator start value: bias of the group about to be computed, aligned to Q format.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) acc_init_s[l] = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (n / NUM_LANES == int'(init_grp_s))
                acc_init_s[n % NUM_LANES] = ACC_W'($signed(bias[n])) <<< FRAC_BITS;
        end
    end
`else
    // Accumulator start value without bias.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) acc_init_s[l] = '0;
    end
`endif

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d   = state_q;
        inputs_d  = inputs_q;
        cnt_d     = cnt_q;
        grp_d     = grp_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        outputs_d = outputs_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (inputs_valid) begin
                    state_d  = ST_MAC;
                    inputs_d = inputs;
                    cnt_d    = '0;
                    grp_d    = '0;
                    addr_d   = '0;
                    acc_d    = acc_init_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (cnt_q != '0) begin
                    for (int l = 0; l < NUM_LANES; l++)
                        acc_d[l] = acc_q[l] + {{(ACC_W-2*DW){prod_s[l][2*DW-1]}}, prod_s[l]};
                end else begin
                    acc_d = acc_q;
                end
                if (cnt_q == CNT_DRAIN) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q < CNT_LAST_ADDR) addr_d = addr_q + ADDR_W'(1);
                    else addr_d = addr_q;
                end
            end
            ST_WRITE: begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    if (n / NUM_LANES == int'(grp_q))
                        outputs_d[n] = activate(sat_shift(acc_q[n % NUM_LANES]));
                end
                acc_d = acc_init_s;
                if (grp_q == GRP_LAST) begin
                    state_d = ST_DONE;
                    addr_d  = '0;
                end else begin
                    state_d = ST_MAC;
                    grp_d   = grp_q + GRP_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                if (valid_q && outputs_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d  = (state_d == ST_MAC) || (state_d == ST_WRITE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers; reset aborts any vector in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            inputs_q  <= '0;
            cnt_q     <= '0;
            grp_q     <= '0;
            addr_q    <= '0;
            for (int l = 0; l < NUM_LANES; l++) acc_q[l] <= '0;
            outputs_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            inputs_q  <= inputs_d;
            cnt_q     <= cnt_d;
            grp_q     <= grp_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            outputs_q <= outputs_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign inputs_ready  = ready_q;
    assign weight_addr   = addr_q;
    assign outputs       = outputs_q;
    assign outputs_valid = valid_q;
    assign busy          = busy_q;

endmodule
